// File: rtl/lsu_mem_unit.sv
// -----------------------------------------------------------------------------
// lsu_mem_unit
//
// Memory-stage load/store unit. It accepts one decoded load or store at a time
// and runs it over a req/gnt/rvalid data bus. Load data comes back aligned and
// sign- or zero-extended, ready for writeback.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned halfword/word accesses take the error path
//               (no bus access, rsp_err one cycle after accept).
//   undefined : the low address bits a halfword/word cannot use are ignored.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake (see below)
//   req_wr, req_rd       store / load select (store wins when both are set)
//   req_op[2:0]          funct3: size in [1:0], unsigned-load flag in [2]
//   req_addr, req_wdata  byte address and rs2 store data
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata, rsp_err   extended load data / error flag, 0 unless rsp_valid
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata   data bus request side
//   bus_gnt              request accepted this cycle
//   bus_rvalid, bus_rdata read data return
//   dbg_state_o          current FSM state, for observation only
//
// Handshake: a request is taken in any cycle where req_valid & req_ready is
// high at the rising edge. req_ready is high only in IDLE, so the caller must
// hold its request until then. On the bus, request fields stay constant from
// the first bus_req cycle until bus_gnt is sampled high; bus_rvalid is only
// looked at while a load waits for its data.
// -----------------------------------------------------------------------------
module lsu_mem_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic            req_rd,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic            we_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] addr_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q;
  logic            err_q;
  logic [XLEN-1:0] rdata_q;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful while accepting in IDLE)
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            is_store;
  logic            is_load;
  logic            op_illegal;
  logic            misaligned;
  logic            req_err;
  logic [3:0]      acc_be;
  logic [XLEN-1:0] acc_wdata;

  assign accept   = req_valid && (state_q == S_IDLE);
  assign is_store = req_wr;
  assign is_load  = !req_wr && req_rd;

  always_comb begin
    op_illegal = 1'b0;
    if (is_store) begin
      op_illegal = !(req_op inside {3'b000, 3'b001, 3'b010});
    end else if (is_load) begin
      op_illegal = (req_op inside {3'b011, 3'b110, 3'b111});
    end else begin
      op_illegal = 1'b1;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (req_op[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign req_err = op_illegal || misaligned;

  // Store lanes: byte enables follow the address, data is replicated so the
  // selected lanes carry the value regardless of offset. Loads read the word.
  always_comb begin
    acc_be    = 4'b1111;
    acc_wdata = '0;
    if (is_store) begin
      case (req_op[1:0])
        2'b00: begin
          acc_be    = 4'b0001 << req_addr[1:0];
          acc_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          acc_be    = req_addr[1] ? 4'b1100 : 4'b0011;
          acc_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          acc_be    = 4'b1111;
          acc_wdata = req_wdata;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load data extraction from the returned word, using the registered request
  // ---------------------------------------------------------------------------
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    ld_byte = 8'h00;
    case (addr_q[1:0])
      2'b00: ld_byte = bus_rdata[7:0];
      2'b01: ld_byte = bus_rdata[15:8];
      2'b10: ld_byte = bus_rdata[23:16];
      2'b11: ld_byte = bus_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q[1:0])
      // op_q[2] set means LBU/LHU: the fill bit is forced to zero.
      2'b00:   ld_data = {{24{ld_byte[7] & ~op_q[2]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~op_q[2]}}, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = req_err ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request / response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= is_store;
        op_q    <= req_op;
        addr_q  <= req_addr;
        be_q    <= acc_be;
        wdata_q <= acc_wdata;
        err_q   <= req_err;
        rdata_q <= '0;
      end else if ((state_q == S_WAIT) && bus_rvalid) begin
        rdata_q <= ld_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: bus fields and response are gated so they read 0 outside their
  // own state, which also gives reset values straight from the state register.
  // ---------------------------------------------------------------------------
  assign req_ready   = (state_q == S_IDLE);
  assign bus_req     = (state_q == S_REQ);
  assign bus_we      = bus_req && we_q;
  assign bus_addr    = bus_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign bus_be      = bus_req ? be_q : 4'b0000;
  assign bus_wdata   = bus_req ? wdata_q : '0;
  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_rdata   = rsp_valid ? rdata_q : '0;
  assign rsp_err     = rsp_valid && err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_unit: directed transactions against a transaction-level model of
// the load/store unit. A negedge monitor compares bus and response outputs
// every cycle; directed cases also pin results to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_lsu_mem_unit;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic        req_rd = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  lsu_mem_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_rd(req_rd), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [32:0] exp_q[$];   // {err, rdata} per expected response
  logic        exp_bus_ok = 1'b0;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata;

  logic [31:0] last_addr;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Model: what a transaction must do, from the access rules alone
  // ---------------------------------------------------------------------------
  task automatic model(input logic wr, input logic rd, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata,
                       output logic err, output logic [3:0] be,
                       output logic [31:0] bwdata, output logic [31:0] res);
    int nbytes;
    int off;
    logic [63:0] v;
    if (wr)      err = (op > 3'd2);
    else if (rd) err = !(op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5);
    else         err = 1'b1;
    nbytes = 1 << op[1:0];
    if (nbytes > 4) nbytes = 4;
`ifdef LSU_MISALIGN_CHECK_EN
    if (!err && (addr % nbytes) != 0) err = 1'b1;
`endif
    off = (int'(addr[1:0]) / nbytes) * nbytes;
    be = 4'(((1 << nbytes) - 1) << off);
    if (nbytes == 1)      bwdata = 32'(wdata[7:0]) * 32'h01010101;
    else if (nbytes == 2) bwdata = 32'(wdata[15:0]) * 32'h00010001;
    else                  bwdata = wdata;
    v = (64'(rdata) >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 64'd1);
    if (!op[2] && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 64'd1) == 64'd1)
      v = v - (64'd1 << (8 * nbytes));
    res = (err || wr) ? 32'h0 : v[31:0];
    if (!wr) be = 4'b1111;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every cycle out of reset
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_req) begin
        check("bus_req_expected", {31'b0, exp_bus_ok}, 32'd1);
        check("bus_we", {31'b0, bus_we}, {31'b0, exp_we});
        check("bus_addr", bus_addr, exp_addr);
        check("bus_be", {28'b0, bus_be}, {28'b0, exp_be});
        if (exp_we) check("bus_wdata", bus_wdata, exp_wdata);
        last_addr  = bus_addr;
        last_be    = bus_be;
        last_wdata = bus_wdata;
      end
      if (rsp_valid) begin
        check("rsp_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
          check("rsp_rdata", rsp_rdata, e[31:0]);
        end
      end else begin
        check("rsp_idle_zero", {rsp_err, rsp_rdata[30:0]} | {31'b0, rsp_rdata[31]}, 32'h0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: call at posedge+1, returns at posedge+1
  // ---------------------------------------------------------------------------
  task automatic run_txn(input logic wr, input logic rd, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int gnt_wait, input int rv_wait,
                         input logic [31:0] rdata,
                         output logic [31:0] got_rdata, output logic got_err);
    logic        err;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] res;
    logic        ld;
    int          c;
    int          exp_lat;
    model(wr, rd, op, addr, wdata, rdata, err, be, bwd, res);
    ld = !wr && rd && !err;
    exp_q.push_back({err, res});
    exp_bus_ok = !err;
    exp_we     = wr;
    exp_addr   = {addr[31:2], 2'b00};
    exp_be     = be;
    exp_wdata  = bwd;
    exp_lat    = err ? 1 : (wr ? 2 + gnt_wait : 3 + gnt_wait + rv_wait);
    got_rdata  = 32'h0;
    got_err    = 1'b0;

    check("req_ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wr = wr; req_rd = rd; req_op = op;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wr = 1'b0; req_rd = 1'b0; req_op = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;

    c = 1;
    while (c < 60) begin
      bus_gnt    = !err && (c == 1 + gnt_wait);
      bus_rvalid = ld && (c == 2 + gnt_wait + rv_wait);
      bus_rdata  = bus_rvalid ? rdata : 32'hDEADBEEF;
      @(negedge clk);
      if (!err && c <= 1 + gnt_wait)
        check("bus_req_held", {31'b0, bus_req}, 32'd1);
      if (rsp_valid) begin
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    check("latency", c, exp_lat);
    @(posedge clk); #1;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    exp_bus_ok = 1'b0;
    check("req_ready_after", {31'b0, req_ready}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] r;
    logic        e;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", {28'b0, bus_be}, 32'h0);
    check("rst_rsp", {30'b0, rsp_valid, rsp_err} | rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SB at 0x1003
    run_txn(1, 0, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0, r, e);
    check("sb_be_lit", {28'b0, last_be}, 32'h8);
    check("sb_addr_lit", last_addr, 32'h0000_1000);
    check("sb_wdata_lit", last_wdata, 32'hA5A5_A5A5);
    check("sb_rdata_lit", r, 32'h0);

    // LB / LBU at 0x2001, rvalid two cycles after grant
    run_txn(0, 1, 3'b000, 32'h0000_2001, 32'h0, 0, 1, 32'h0000_F000, r, e);
    check("lb_lit", r, 32'hFFFF_FFF0);
    run_txn(0, 1, 3'b100, 32'h0000_2001, 32'h0, 0, 1, 32'h0000_F000, r, e);
    check("lbu_lit", r, 32'h0000_00F0);

    // LH / LW with three un-granted cycles
    run_txn(0, 1, 3'b001, 32'h0000_2002, 32'h0, 3, 0, 32'h8000_1234, r, e);
    check("lh_lit", r, 32'hFFFF_8000);
    run_txn(0, 1, 3'b010, 32'h0000_2000, 32'h0, 3, 0, 32'h8000_1234, r, e);
    check("lw_lit", r, 32'h8000_1234);

    // Other lanes and extensions
    run_txn(0, 1, 3'b101, 32'h0000_2000, 32'h0, 1, 2, 32'h5555_ABCD, r, e);
    check("lhu_lit", r, 32'h0000_ABCD);
    run_txn(0, 1, 3'b000, 32'h0000_2003, 32'h0, 0, 0, 32'h7F00_0000, r, e);
    check("lb_hi_lit", r, 32'h0000_007F);
    run_txn(1, 0, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 1, 0, 32'h0, r, e);
    check("sh_be_lit", {28'b0, last_be}, 32'hC);
    check("sh_wdata_lit", last_wdata, 32'hBEEF_BEEF);
    run_txn(1, 1, 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 0, 0, 32'h0, r, e);
    check("sw_both_be_lit", {28'b0, last_be}, 32'hF);
    check("sw_both_wdata_lit", last_wdata, 32'hCAFE_F00D);

    // Illegal ops
    run_txn(1, 0, 3'b100, 32'h0000_1000, 32'h1, 0, 0, 32'h0, r, e);
    check("ill_st_err_lit", {31'b0, e}, 32'd1);
    run_txn(0, 1, 3'b011, 32'h0000_1000, 32'h0, 0, 0, 32'h0, r, e);
    check("ill_ld_err_lit", {31'b0, e}, 32'd1);
    run_txn(0, 0, 3'b010, 32'h0000_1000, 32'h0, 0, 0, 32'h0, r, e);
    check("ill_none_err_lit", {31'b0, e}, 32'd1);

    // Misaligned word
    run_txn(0, 1, 3'b010, 32'h0000_3002, 32'h0, 0, 0, 32'h1357_9BDF, r, e);
`ifdef LSU_MISALIGN_CHECK_EN
    check("lw_mis_err_lit", {31'b0, e}, 32'd1);
    check("lw_mis_rdata_lit", r, 32'h0);
`else
    check("lw_mis_err_lit", {31'b0, e}, 32'd0);
    check("lw_mis_addr_lit", last_addr, 32'h0000_3000);
    check("lw_mis_rdata_lit", r, 32'h1357_9BDF);
`endif

    // Reset while waiting for load data
    exp_bus_ok = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_4000; exp_be = 4'hF;
    exp_q.push_back({1'b0, 32'h1111_2222});
    req_valid = 1'b1; req_rd = 1'b1; req_op = 3'b010; req_addr = 32'h0000_4000;
    @(posedge clk); #1;
    req_valid = 1'b0; req_rd = 1'b0; req_addr = 32'h0;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    exp_bus_ok = 1'b0;
    #2;
    check("rst_mid_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
      check("rst_mid_idle", {31'b0, req_ready}, 32'd1);
    end
    @(posedge clk); #1;
    run_txn(1, 0, 3'b010, 32'h0000_4008, 32'h0BAD_F00D, 0, 0, 32'h0, r, e);
    check("sw_after_rst_addr_lit", last_addr, 32'h0000_4008);
    check("sw_after_rst_err_lit", {31'b0, e}, 32'd0);

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
